// File: rtl/isqrt_pkg.sv
// Shared definitions for the iterative integer square root.
// State encoding and derived root/remainder widths.
package isqrt_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        GET_A = 2'd0,
        CALC  = 2'd1,
        PUT_Z = 2'd2
    } state_t;

    function automatic int root_w(input int w);
        return w / 2;
    endfunction

    function automatic int rem_w(input int w);
        return w / 2 + 1;
    endfunction

    localparam int ROOT_W = root_w(DEF_WIDTH);
    localparam int REM_W  = rem_w(DEF_WIDTH);

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit iteration of the square-root recurrence.
// Consumes two radicand bits, produces one root bit.
module isqrt_step #(
    parameter int RW = 16
) (
    input  logic [RW:0]   rem_i,
    input  logic [RW-1:0] root_i,
    input  logic [1:0]    bits_i,
    output logic [RW:0]   rem_o,
    output logic [RW-1:0] root_o
);

    localparam int TW = RW + 3;

    logic [TW-1:0] cat;
    logic [TW-1:0] sub;
    logic [TW-1:0] trial;

    assign cat   = {rem_i, bits_i};
    assign sub   = {1'b0, root_i, 2'b01};
    assign trial = cat - sub;

    // Sign bit of the trial difference selects restore vs. keep
    always_comb begin
        if (!trial[TW-1]) begin
            rem_o  = trial[RW:0];
            root_o = {root_i[RW-2:0], 1'b1};
        end else begin
            rem_o  = cat[RW:0];
            root_o = {root_i[RW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential unsigned integer square root, one root bit per clock.
// stb/ack handshakes on both the radicand input and the result output.
import isqrt_pkg::*;

module isqrt_seq #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_a,
    input  logic               in_a_stb,
    output logic               in_a_ack,
    output logic [WIDTH/2-1:0] out_z,
    output logic [WIDTH/2:0]   out_rem,
    output logic               out_z_stb,
    input  logic               out_z_ack
);

    localparam int RW = root_w(WIDTH);
    localparam int MW = rem_w(WIDTH);
    localparam int CW = $clog2(RW);

    state_t          state_q, state_d;
    logic            ack_q, ack_d;
    logic            stb_q, stb_d;
    logic [RW-1:0]   z_q, z_d;
    logic [MW-1:0]   zr_q, zr_d;
    logic [WIDTH-1:0] rad_q, rad_d;
    logic [RW-1:0]   root_q, root_d;
    logic [MW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [MW-1:0]   step_rem;
    logic [RW-1:0]   step_root;

    isqrt_step #(
        .RW(RW)
    ) u_step (
        .rem_i  (acc_q),
        .root_i (root_q),
        .bits_i (rad_q[WIDTH-1 -: 2]),
        .rem_o  (step_rem),
        .root_o (step_root)
    );

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        stb_d   = stb_q;
        z_d     = z_q;
        zr_d    = zr_q;
        rad_d   = rad_q;
        root_d  = root_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            GET_A: begin
                ack_d = 1'b1;
                if (in_a_stb && ack_q) begin
                    rad_d   = in_a;
                    root_d  = '0;
                    acc_d   = '0;
                    cnt_d   = CW'(RW - 1);
                    ack_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                root_d = step_root;
                acc_d  = step_rem;
                rad_d  = {rad_q[WIDTH-3:0], 2'b00};
                if (cnt_q == '0) begin
                    z_d     = step_root;
                    zr_d    = step_rem;
                    stb_d   = 1'b1;
                    state_d = PUT_Z;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PUT_Z: begin
                if (out_z_ack) begin
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            ack_q   <= 1'b0;
            stb_q   <= 1'b0;
            z_q     <= '0;
            zr_q    <= '0;
            rad_q   <= '0;
            root_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            stb_q   <= stb_d;
            z_q     <= z_d;
            zr_q    <= zr_d;
            rad_q   <= rad_d;
            root_q  <= root_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_a_ack  = ack_q;
    assign out_z_stb = stb_q;
    assign out_z     = z_q;
    assign out_rem   = zr_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed and random checks of isqrt_seq against an arithmetic sqrt model.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_isqrt_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a;
    logic        in_a_stb;
    logic        in_a_ack;
    logic [15:0] out_z;
    logic [16:0] out_rem;
    logic        out_z_stb;
    logic        out_z_ack;

    int n_chk  = 0;
    int n_fail = 0;
    longint cyc = 0;
    longint hs_cyc = 0;
    longint prev_hs = 0;

    isqrt_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_a_stb  (in_a_stb),
        .in_a_ack  (in_a_ack),
        .out_z     (out_z),
        .out_rem   (out_rem),
        .out_z_stb (out_z_stb),
        .out_z_ack (out_z_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: floor(sqrt(a)) via real arithmetic, corrected by exact integer tests
    task automatic ref_sqrt(input longint a, output longint z, output longint r);
        z = longint'($sqrt(real'(a)));
        while (z * z > a) z--;
        while ((z + 1) * (z + 1) <= a) z++;
        r = a - z * z;
    endtask

    task automatic run_op(input logic [31:0] a, input int hold, input bit chk_tp);
        longint ez, er;
        int w, lat;
        ref_sqrt(longint'(a), ez, er);
        in_a      = a;
        in_a_stb  = 1'b1;
        out_z_ack = (hold == 0);
        w = 0;
        while (!in_a_ack && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) check("hs_timeout", 1, 0);
        @(posedge clk);
        prev_hs = hs_cyc;
        hs_cyc  = cyc;
        #1;
        in_a_stb = 1'b0;
        check("ack_drop", longint'(in_a_ack), 0);
        if (chk_tp) check("throughput", hs_cyc - prev_hs, 18);
        lat = 0;
        while (!out_z_stb && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 16);
        check("z", longint'(out_z), ez);
        check("rem", longint'(out_rem), er);
        for (int i = 0; i < hold; i++) begin
            in_a_stb = i[0];
            in_a     = ~a;
            @(posedge clk); #1;
            check("bp_stb", longint'(out_z_stb), 1);
            check("bp_z", longint'(out_z), ez);
            check("bp_rem", longint'(out_rem), er);
            check("bp_inack", longint'(in_a_ack), 0);
        end
        in_a_stb  = 1'b0;
        out_z_ack = 1'b1;
        @(posedge clk); #1;
        check("stb_drop", longint'(out_z_stb), 0);
        check("inack_rise", longint'(in_a_ack), 1);
        check("z_hold", longint'(out_z), ez);
    endtask

    initial begin
        bit rose;
        int w;
        rst       = 1'b1;
        in_a      = '0;
        in_a_stb  = 1'b0;
        out_z_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inack", longint'(in_a_ack), 0);
        check("rst_stb", longint'(out_z_stb), 0);
        check("rst_z", longint'(out_z), 0);
        check("rst_rem", longint'(out_rem), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("inack_after_rst", longint'(in_a_ack), 1);

        run_op(32'd0, 0, 1'b0);
        run_op(32'd1000000, 0, 1'b0);
        run_op(32'd99, 0, 1'b1);
        run_op(32'hFFFFFFFF, 0, 1'b1);
        run_op(32'h00000003, 0, 1'b1);
        run_op(32'd50, 10, 1'b0);

        // Abort mid-computation; no result may appear
        in_a     = 32'd1000;
        in_a_stb = 1'b1;
        w = 0;
        while (!in_a_ack && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) check("abort_hs_timeout", 1, 0);
        @(posedge clk); #1;
        in_a_stb = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_stb", longint'(out_z_stb), 0);
        check("abort_z", longint'(out_z), 0);
        check("abort_inack", longint'(in_a_ack), 0);
        rose = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_z_stb) rose = 1'b1;
        end
        check("abort_no_result", longint'(rose), 0);
        run_op(32'd144, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] r;
            r = $urandom;
            if (i % 4 == 1) r = r >> $urandom_range(31, 0);
            run_op(r, (i % 50 == 7) ? 3 : 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
